// File: rtl/clock_display_pkg.sv
// Shared constants and state encoding for the clock display scan path.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, segments {g,f,e,d,c,b,a} active-high.
module bcd_to_7seg
  import clock_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with per-frame input snapshot.
// Optional LEADING_ZERO_BLANK_EN: blank the hours-tens digit when it is zero.
//
// state | meaning
// IDLE  | display dark, waiting for i_enable
// BLANK | all digits off ahead of the current digit
// ON    | current digit lit from the frame snapshot
module display_scan_driver
  import clock_display_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int ON_CYCLES    = 240
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [3:0] i_hours_h_bcd,
  input  logic [3:0] i_hours_l_bcd,
  input  logic [3:0] i_minutes_h_bcd,
  input  logic [3:0] i_minutes_l_bcd,
  input  logic [3:0] i_seconds_h_bcd,
  input  logic [3:0] i_seconds_l_bcd,
  input  logic [5:0] i_dp_segs,
  output logic [6:0] o_segments,
  output logic       o_dp,
  output logic [5:0] o_digit_en,
  output logic       o_frame_stb
);

  localparam int MAX_CYC = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

  scan_state_t r_state, w_next_state;
  logic [2:0]  r_idx, w_next_idx;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic        w_load_snap;

  logic [4*NUM_DIGITS-1:0] r_snap_bcd;
  logic [NUM_DIGITS-1:0]   r_snap_dp;

  logic [3:0] w_cur_bcd;
  logic [6:0] w_dec_seg;
  logic       w_lit;
  logic       w_blank_lz;
  logic       w_frame_end;

  logic [6:0]            r_segments;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_stb;

  // Phase counter counts down to zero; terminal count ends the phase.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_cnt   = r_cnt;
    w_load_snap  = 1'b0;
    if (!i_enable) begin
      w_next_state = IDLE;
      w_next_idx   = 3'd0;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = BLANK;
          w_next_idx   = 3'd0;
          w_next_cnt   = BLANK_LOAD;
          w_load_snap  = 1'b1;
        end
        BLANK: begin
          if (r_cnt == '0) begin
            w_next_state = ON;
            w_next_cnt   = ON_LOAD;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        ON: begin
          if (r_cnt == '0) begin
            w_next_state = BLANK;
            w_next_cnt   = BLANK_LOAD;
            if (r_idx == LAST_IDX) begin
              w_next_idx  = 3'd0;
              w_load_snap = 1'b1;
            end else begin
              w_next_idx = r_idx + 3'd1;
            end
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_idx   = 3'd0;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= '0;
      r_snap_bcd <= '0;
      r_snap_dp  <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_cnt   <= w_next_cnt;
      if (w_load_snap) begin
        r_snap_bcd <= {i_hours_h_bcd, i_hours_l_bcd, i_minutes_h_bcd,
                       i_minutes_l_bcd, i_seconds_h_bcd, i_seconds_l_bcd};
        r_snap_dp  <= i_dp_segs;
      end
    end
  end

  // Outputs are registered from the next state, so they track the state the FSM is in.
  // The snapshot never changes on entry to ON, so the current snapshot is safe to decode.
  assign w_cur_bcd = r_snap_bcd[{w_next_idx, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .i_bcd (w_cur_bcd),
    .o_seg (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_lz = (w_next_idx == LAST_IDX) && (r_snap_bcd[4*NUM_DIGITS-1 -: 4] == 4'd0);
`else
  assign w_blank_lz = 1'b0;
`endif

  assign w_lit       = (w_next_state == ON);
  assign w_frame_end = w_lit && (w_next_idx == LAST_IDX) && (w_next_cnt == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_segments  <= '0;
      r_dp        <= 1'b0;
      r_digit_en  <= '0;
      r_frame_stb <= 1'b0;
    end else begin
      r_segments  <= (w_lit && !w_blank_lz) ? w_dec_seg : '0;
      r_dp        <= w_lit && !w_blank_lz && r_snap_dp[w_next_idx];
      r_digit_en  <= w_lit ? (NUM_DIGITS'(1) << w_next_idx) : '0;
      r_frame_stb <= w_frame_end;
    end
  end

  assign o_segments  = r_segments;
  assign o_dp        = r_dp;
  assign o_digit_en  = r_digit_en;
  assign o_frame_stb = r_frame_stb;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver against a frame-position reference model.
module tb_display_scan_driver;

  localparam int B     = 2;
  localparam int O     = 4;
  localparam int SLOT  = B + O;
  localparam int FRAME = 6 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] hh = 0, hl = 0, mh = 0, ml = 0, sh = 0, sl = 0;
  logic [5:0] dps = 0;
  logic [6:0] o_segments;
  logic       o_dp;
  logic [5:0] o_digit_en;
  logic       o_frame_stb;

  int checks = 0;
  int fails  = 0;

  display_scan_driver #(.BLANK_CYCLES(B), .ON_CYCLES(O)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_hours_h_bcd   (hh),
    .i_hours_l_bcd   (hl),
    .i_minutes_h_bcd (mh),
    .i_minutes_l_bcd (ml),
    .i_seconds_h_bcd (sh),
    .i_seconds_l_bcd (sl),
    .i_dp_segs       (dps),
    .o_segments      (o_segments),
    .o_dp            (o_dp),
    .o_digit_en      (o_digit_en),
    .o_frame_stb     (o_frame_stb)
  );

  always #5 clk = ~clk;

  // Reference model: the frame is a fixed timeline of SLOT-long slots per digit,
  // each slot dark for B cycles then lit for O; inputs are captured at frame start.
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [3:0] m_bcd [6];
  logic [5:0] m_dp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_t = 0;
    end else if (!en) begin
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
      if (m_t % FRAME == 0) begin
        m_bcd[0] = sl; m_bcd[1] = sh; m_bcd[2] = ml;
        m_bcd[3] = mh; m_bcd[4] = hl; m_bcd[5] = hh;
        m_dp = dps;
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v < 10) ? tbl[v] : 7'h40;
  endfunction

  function automatic logic [14:0] exp_vec();
    int p, d;
    logic [6:0] s;
    logic dv;
    logic [5:0] de;
    if (!m_active) return '0;
    p  = m_t % FRAME;
    d  = p / SLOT;
    s  = seg_of(m_bcd[d]);
    dv = m_dp[d];
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 5 && m_bcd[5] == 4'd0) begin s = '0; dv = 1'b0; end
`endif
    de = 6'(1) << d;
    if ((p % SLOT) < B) begin s = '0; dv = 1'b0; de = '0; end
    return {s, dv, de, (p == FRAME - 1)};
  endfunction

  task automatic set_digits(input logic [3:0] a, b, c, d, e, f, input logic [5:0] p);
    hh = a; hl = b; mh = c; ml = d; sh = e; sl = f; dps = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== 15'd0) begin
        fails++;
        $display("FAIL reset cyc=%0d got=%h exp=0", i, {o_segments, o_dp, o_digit_en, o_frame_stb});
      end
    end
  endtask

  task automatic test_first_frame();
    int first_on = -1, n_stb = 0, stb_at = -1;
    set_digits(4'd2, 4'd3, 4'd5, 4'd8, 4'd0, 4'd6, 6'b100001);
    en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL first_frame cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
      if (o_digit_en == 6'b000001 && first_on < 0) first_on = i;
      if (o_frame_stb) begin n_stb++; stb_at = i; end
    end
    checks++;
    if (first_on !== 2) begin fails++; $display("FAIL first_on got=%0d exp=2", first_on); end
    checks++;
    if (n_stb !== 1 || stb_at !== FRAME - 1) begin
      fails++;
      $display("FAIL frame_stb count=%0d at=%0d exp count=1 at=%0d", n_stb, stb_at, FRAME - 1);
    end
  endtask

  task automatic test_pattern();
    bit seen = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 6'b010100);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL pattern cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
      if (seen && o_digit_en != 0) begin
        checks++;
        if (o_dp !== ((o_digit_en & 6'b010100) != 0)) begin
          fails++;
          $display("FAIL pattern_dp en=%b got=%b", o_digit_en, o_dp);
        end
        if (o_digit_en == 6'b000001) begin
          checks++;
          if (o_segments !== 7'h6F) begin fails++; $display("FAIL sec_l got=%h exp=6f", o_segments); end
        end
        if (o_digit_en == 6'b100000) begin
          checks++;
          if (o_segments !== 7'h06) begin fails++; $display("FAIL hr_h got=%h exp=06", o_segments); end
        end
      end
      if (o_frame_stb) seen = 1'b1;
    end
  endtask

  task automatic test_midframe_change();
    bit reached = 1'b0;
    int frames = 0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 6'b000000);
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      @(negedge clk);
      if (m_active && m_t % FRAME == B && m_bcd[2] == 4'd4) reached = 1'b1;
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL midframe_wait got=timeout exp=digit0_on"); end
    ml = 4'd7;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL midframe cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
      if (o_digit_en == 6'b000100) begin
        checks++;
        if (o_segments !== ((frames == 0) ? 7'h66 : 7'h07)) begin
          fails++;
          $display("FAIL min_l frame=%0d got=%h exp=%h", frames, o_segments, (frames == 0) ? 7'h66 : 7'h07);
        end
      end
      if (o_frame_stb) frames++;
    end
  endtask

  task automatic test_dash();
    bit seen = 1'b0;
    sh = 4'hC;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL dash cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
      if (seen && o_digit_en == 6'b000010) begin
        checks++;
        if (o_segments !== 7'h40) begin fails++; $display("FAIL dash_seg got=%h exp=40", o_segments); end
      end
      if (o_frame_stb) seen = 1'b1;
    end
  endtask

  task automatic test_enable_drop();
    bit reached = 1'b0;
    int first_on = -1;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      @(negedge clk);
      if (m_active && m_t % FRAME == 3 * SLOT + B + 1) reached = 1'b1;
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL drop_wait got=timeout exp=digit3_on"); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== 15'd0) begin
        fails++;
        $display("FAIL disabled cyc=%0d got=%h exp=0", i, {o_segments, o_dp, o_digit_en, o_frame_stb});
      end
    end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL reenable cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
      if (o_digit_en != 0 && first_on < 0) begin
        first_on = i;
        checks++;
        if (o_digit_en !== 6'b000001 || i !== B) begin
          fails++;
          $display("FAIL resume en=%b at=%0d exp en=000001 at=%0d", o_digit_en, i, B);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    bit seen = 1'b0;
    int n5 = 0;
    logic [6:0] want;
`ifdef LEADING_ZERO_BLANK_EN
    want = 7'h00;
`else
    want = 7'h3F;
`endif
    set_digits(4'd0, 4'd7, 4'd2, 4'd6, 4'd1, 4'd8, 6'b100000);
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL lz cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
      if (seen && o_digit_en[5]) begin
        n5++;
        checks++;
        if (o_segments !== want) begin fails++; $display("FAIL lz_seg got=%h exp=%h", o_segments, want); end
      end
      if (o_frame_stb) seen = 1'b1;
    end
    checks++;
    if (n5 !== O) begin fails++; $display("FAIL lz_digit_en5 count=%0d exp=%0d", n5, O); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
      if ($urandom_range(0, 9) == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   6'($urandom_range(0, 63)));
      if ($urandom_range(0, 79) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    int wait_n = $urandom_range(FRAME / 2, FRAME + 10);
    repeat (wait_n) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== 15'd0) begin
      fails++;
      $display("FAIL async_reset got=%h exp=0", {o_segments, o_dp, o_digit_en, o_frame_stb});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({o_segments, o_dp, o_digit_en, o_frame_stb} !== exp_vec()) begin
        fails++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, {o_segments, o_dp, o_digit_en, o_frame_stb}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_pattern();
    test_midframe_change();
    test_dash();
    test_enable_drop();
    test_leading_zero();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
